// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the single register-bank write port between two writeback
// requesters (0: ALU, 1: load/multi-cycle unit). At most one write is accepted
// per cycle. A lone requester wins outright. When both are valid, the
// requester that did not win the last transfer wins (round-robin). The
// accepted write is presented on the registered write port one cycle later.
//
// Ports
//   clk            the only clock; state updates on the rising edge
//   rst            asynchronous, active-high reset
//   reqN_valid     requester N has a pending write (N = 0, 1)
//   reqN_reg       requester N destination register
//   reqN_data      requester N write data
//   reqN_ready     combinational: requester N's write is accepted this cycle
//   wb_stall       blocks all grants while high
//   regwrite       registered write enable to the register bank
//   wrreg          registered write address
//   wrdata         registered write data
//   grant_id       registered id of the requester behind the current write
//   conflict_cnt   saturating count of cycles with both valid and no stall
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              wb_stall,
  output logic              regwrite,
  output logic [ADDR_W-1:0] wrreg,
  output logic [DATA_W-1:0] wrdata,
  output logic              grant_id,
  output logic [7:0]        conflict_cnt
);

  logic              last_grant_q, last_grant_d;
  logic              regwrite_q,   regwrite_d;
  logic [ADDR_W-1:0] wrreg_q,      wrreg_d;
  logic [DATA_W-1:0] wrdata_q,     wrdata_d;
  logic              grant_id_q,   grant_id_d;
  logic [7:0]        conflict_q,   conflict_d;

  logic              win0, win1, xfer, both_valid;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    both_valid = req0_valid & req1_valid;
    // last_grant_q == 1 means requester 1 won last, so requester 0 has priority.
    win0       = req0_valid & (~req1_valid |  last_grant_q);
    win1       = req1_valid & (~req0_valid | ~last_grant_q);
    req0_ready = win0 & ~wb_stall & ~rst;
    req1_ready = win1 & ~wb_stall & ~rst;
    xfer       = req0_ready | req1_ready;
    sel_reg    = req1_ready ? req1_reg  : req0_reg;
    sel_data   = req1_ready ? req1_data : req0_data;

    last_grant_d = last_grant_q;
    regwrite_d   = 1'b0;
    wrreg_d      = wrreg_q;
    wrdata_d     = wrdata_q;
    grant_id_d   = grant_id_q;
    conflict_d   = conflict_q;

    if (xfer) begin
      last_grant_d = req1_ready;
      // Register 0 is hardwired: accept the transfer but suppress the write.
      regwrite_d   = (sel_reg != '0);
      wrreg_d      = sel_reg;
      wrdata_d     = sel_data;
      grant_id_d   = req1_ready;
    end

    if (both_valid && !wb_stall && conflict_q != 8'hFF) begin
      conflict_d = conflict_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled at the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;  // requester 0 wins the first conflict
      regwrite_q   <= 1'b0;
      wrreg_q      <= '0;
      wrdata_q     <= '0;
      grant_id_q   <= 1'b0;
      conflict_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      regwrite_q   <= regwrite_d;
      wrreg_q      <= wrreg_d;
      wrdata_q     <= wrdata_d;
      grant_id_q   <= grant_id_d;
      conflict_q   <= conflict_d;
    end
  end

  assign regwrite     = regwrite_q;
  assign wrreg        = wrreg_q;
  assign wrdata       = wrdata_q;
  assign grant_id     = grant_id_q;
  assign conflict_cnt = conflict_q;

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter: DATA_W, default 32, width of write data.
REQ-002 Parameter: ADDR_W, default 5, width of register address.
REQ-003 Port: clk  input  1  the only clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: req0_valid  input  1  requester 0 (ALU writeback) has a pending write.
REQ-006 Port: req0_reg  input  ADDR_W  requester 0 destination register.
REQ-007 Port: req0_data  input  DATA_W  requester 0 write data.
REQ-008 Port: req0_ready  output  1  requester 0 write accepted this cycle.
REQ-009 Port: req1_valid, req1_reg, req1_data, req1_ready  same directions/widths; requester 1 (load/multi-cycle unit).
REQ-010 Port: wb_stall  input  1  blocks all grants while high.
REQ-011 Port: regwrite  output  1  registered write enable to the register bank.
REQ-012 Port: wrreg  output  ADDR_W  registered write address to the register bank.
REQ-013 Port: wrdata  output  DATA_W  registered write data to the register bank.
REQ-014 Port: grant_id  output  1  registered id of the requester behind the current regwrite.
REQ-015 Port: conflict_cnt  output  8  saturating count of cycles with both requesters valid and wb_stall low.

Function
REQ-016 The block SHALL share the single register-bank write port between two requesters, issuing at most one write per cycle.
REQ-017 reqN_ready SHALL be combinational: high only when reqN_valid is high, rst is low, wb_stall is low, and requester N wins arbitration.
REQ-018 Transfer = reqN_valid & reqN_ready; requesters SHALL hold valid/reg/data stable until transfer.
REQ-019 Only one valid: that requester SHALL win.
REQ-020 Both valid: the requester not equal to last_grant SHALL win (round-robin).
REQ-021 last_grant SHALL update to the winner on every transfer and hold otherwise.
REQ-022 Latency: one cycle; on the edge after a transfer, regwrite/wrreg/wrdata/grant_id SHALL reflect the accepted request.
REQ-023 A transfer with reg = 0 SHALL be accepted (ready high) but produce regwrite = 0 the next cycle; wrreg/wrdata/grant_id still load.
REQ-024 In a cycle with no transfer, regwrite SHALL be 0 the next cycle; wrreg/wrdata/grant_id hold.
REQ-025 wb_stall high SHALL force both readies low and not change last_grant.
REQ-026 conflict_cnt SHALL increment on each cycle with both valid and wb_stall low, saturating at 255 (no wrap).
REQ-027 Back-to-back transfers SHALL be sustained: one write per cycle with no bubble while any requester is valid and wb_stall low.

Reset
REQ-028 While rst is high: regwrite = 0, wrreg = 0, wrdata = 0, grant_id = 0, conflict_cnt = 0, both readies 0.
REQ-029 last_grant SHALL reset to 1, so requester 0 wins the first conflict.
REQ-030 Reset asserted mid-operation SHALL clear state immediately (asynchronously); a write registered but not yet presented SHALL be dropped.

Verification
REQ-031 Only req0 valid, reg=3, data=0xA5A5A5A5 -> req0_ready=1; next cycle regwrite=1, wrreg=3, wrdata=0xA5A5A5A5, grant_id=0.
REQ-032 After reset, both valid for 4 cycles (req0 reg=1, req1 reg=2) -> grants 0,1,0,1; regwrite high 4 consecutive cycles; conflict_cnt=4.
REQ-033 req1 valid, reg=0, data=0xFFFFFFFF -> req1_ready=1; next cycle regwrite=0, wrreg=0, grant_id=1.
REQ-034 Both valid with wb_stall=1 for 3 cycles, then low -> no readies during stall, conflict_cnt unchanged, first grant after stall goes to requester opposite last_grant.
REQ-035 Both valid held for 300 cycles -> conflict_cnt reaches 255 and stays 255.
REQ-036 rst pulsed asynchronously between edges while regwrite=1 -> regwrite, wrreg, wrdata, conflict_cnt read 0 before the next clock edge.
